alu_issue_ctrl: RTL and testbench
=================================

Name: alu_issue_ctrl

Overview:
- Upstream stage of the ALU. Holds a small register file and accepts one instruction at a time (opcode, RD, RS, RT) over a valid/ready handshake.
- Drives ALU operands and opcode, waits for ALU done, and writes the ALU result back to the register file.
- Captures the high product word and the zero flag, and aborts with an error if the ALU never completes.

Parameters:
- DATA_WIDTH, 32, operand/result width (matches `DATA_WIDTH).
- OPRN_WIDTH, 6, ALU opcode width (matches `ALU_OPRN_WIDTH).
- REG_ADDR_WIDTH, 4, register address width; 2**REG_ADDR_WIDTH registers.
- TIMEOUT, 16, max EXEC cycles waiting for ALU_DONE before abort.

Ports:
- CLK  in  1  clock; all state updates on rising edge.
- RST  in  1  synchronous, active-low reset.
- INST_VALID  in  1  instruction present.
- INST_READY  out  1  block can accept an instruction.
- INST_OPRN  in  OPRN_WIDTH  ALU opcode.
- INST_RD  in  REG_ADDR_WIDTH  destination register.
- INST_RS  in  REG_ADDR_WIDTH  op1 source register.
- INST_RT  in  REG_ADDR_WIDTH  op2 source register.
- LD_EN  in  1  preload write enable.
- LD_ADDR  in  REG_ADDR_WIDTH  preload address.
- LD_DATA  in  DATA_WIDTH  preload data.
- DBG_ADDR  in  REG_ADDR_WIDTH  debug read address.
- DBG_DATA  out  DATA_WIDTH  combinational read of regfile[DBG_ADDR].
- ALU_OP1  out  DATA_WIDTH  registered operand 1 to ALU.
- ALU_OP2  out  DATA_WIDTH  registered operand 2 to ALU.
- ALU_OPRN  out  OPRN_WIDTH  registered opcode to ALU.
- ALU_RL  in  DATA_WIDTH  ALU low result.
- ALU_RH  in  DATA_WIDTH  ALU high result (multiply).
- ALU_ZERO  in  1  ALU zero flag.
- ALU_DONE  in  1  ALU result valid (level).
- HI  out  DATA_WIDTH  last multiply high word.
- ZERO_FLAG  out  1  ALU_ZERO captured at last writeback.
- BUSY  out  1  state != IDLE.
- ERR_TIMEOUT  out  1  sticky; set on timeout abort.
- ERR_ILLEGAL  out  1  sticky; set on illegal opcode.

Behaviour:
- Reset (RST low at a rising edge) forces the following, regardless of state:
  - All registers = 0; ALU_OP1/OP2/OPRN = 0; HI = 0; ZERO_FLAG = 0.
  - ERR_* = 0; state = IDLE; INST_READY = 0 while RST low.
  - An in-flight instruction is discarded with no writeback.
- Legal opcodes: 0x01 to 0x09; every other value is illegal.
- States: IDLE, READ, EXEC, WB.
- IDLE:
  - INST_READY = 1.
  - An instruction is accepted on an edge with INST_VALID & INST_READY; RD/RS/RT/OPRN are latched.
  - Legal opcode: go to READ.
  - Illegal opcode: set ERR_ILLEGAL, stay in IDLE; the instruction is consumed and nothing else changes.
- READ (1 cycle):
  - INST_READY = 0.
  - ALU_OP1 <= reg[RS], ALU_OP2 <= reg[RT], ALU_OPRN <= latched opcode.
  - Go to EXEC and clear the timeout counter.
- EXEC:
  - Outputs held stable.
  - ALU_DONE is ignored in the first EXEC cycle, so a stale done from the previous op is never taken.
  - From the 2nd EXEC cycle on, ALU_DONE = 1 at an edge latches RL/RH/ZERO and moves to WB.
  - The counter increments each EXEC cycle. If it reaches TIMEOUT without done: set ERR_TIMEOUT, return to IDLE, no writeback.
- WB (1 cycle):
  - reg[RD] <= RL; ZERO_FLAG <= ALU_ZERO.
  - If opcode = 0x03, HI <= RH; otherwise HI is unchanged.
  - Go to IDLE.
- Latency: accept edge to WB edge = 4 edges minimum (accept, READ, EXEC x2). The next instruction can be accepted at the edge after WB.
- Register 0 is ordinary (not hardwired) and is writable.
- RS = RT = RD is legal: operands are read in READ, written in WB.
- LD_EN:
  - Honoured only in IDLE; ignored in all other states.
  - If the same edge also accepts an instruction, the preload write completes first. The instruction's READ (next cycle) sees the preloaded value.
- Simultaneous preload to RD and WB cannot occur, because preload is only honoured in IDLE.
- ERR flags are sticky until reset.
- ALU_OP*/OPRN retain their last values in IDLE.

Test Plan:
- Preload r1=15, r2=3; issue {0x01, RD=3, RS=1, RT=2}; ALU done 1 cycle after EXEC entry -> r3=18, ZERO_FLAG=0, BUSY high for 4 cycles, INST_READY back to 1.
- Preload r1=15, r2=5; issue {0x03, RD=4, RS=1, RT=2} with ALU returning RH=0, RL=75 -> r4=75, HI=0. Then {0x02, RD=5, RS=2, RT=2} -> r5=0, ZERO_FLAG=1, HI unchanged.
- Hold ALU_DONE high continuously from the previous op; issue a new op -> done is not taken in the first EXEC cycle; WB happens no earlier than the 2nd EXEC cycle.
- ALU_DONE held low, TIMEOUT=16 -> after 16 EXEC cycles ERR_TIMEOUT=1, state IDLE, RD register unchanged.
- Issue opcode 0x00 and 0x3F -> ERR_ILLEGAL=1, BUSY never asserts, no register changes. Then issue a legal op -> it executes normally.
- Assert RST low during EXEC -> next edge: all regs 0, outputs 0, IDLE, no writeback. INST_READY=1 on the first edge after RST returns high.

Source files
------------

// File: rtl/alu_issue_ctrl.sv
// Issue stage in front of the ALU: small register file, one instruction in flight,
// operand fetch, bounded wait for ALU completion and result writeback.
module alu_issue_ctrl #(
  parameter int DATA_WIDTH     = 32,
  parameter int OPRN_WIDTH     = 6,
  parameter int REG_ADDR_WIDTH = 4,
  parameter int TIMEOUT        = 16
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic                      INST_VALID,
  output logic                      INST_READY,
  input  logic [OPRN_WIDTH-1:0]     INST_OPRN,
  input  logic [REG_ADDR_WIDTH-1:0] INST_RD,
  input  logic [REG_ADDR_WIDTH-1:0] INST_RS,
  input  logic [REG_ADDR_WIDTH-1:0] INST_RT,
  input  logic                      LD_EN,
  input  logic [REG_ADDR_WIDTH-1:0] LD_ADDR,
  input  logic [DATA_WIDTH-1:0]     LD_DATA,
  input  logic [REG_ADDR_WIDTH-1:0] DBG_ADDR,
  output logic [DATA_WIDTH-1:0]     DBG_DATA,
  output logic [DATA_WIDTH-1:0]     ALU_OP1,
  output logic [DATA_WIDTH-1:0]     ALU_OP2,
  output logic [OPRN_WIDTH-1:0]     ALU_OPRN,
  input  logic [DATA_WIDTH-1:0]     ALU_RL,
  input  logic [DATA_WIDTH-1:0]     ALU_RH,
  input  logic                      ALU_ZERO,
  input  logic                      ALU_DONE,
  output logic [DATA_WIDTH-1:0]     HI,
  output logic                      ZERO_FLAG,
  output logic                      BUSY,
  output logic                      ERR_TIMEOUT,
  output logic                      ERR_ILLEGAL
);

  localparam int NREG = 2**REG_ADDR_WIDTH;
  localparam int CW   = $clog2(TIMEOUT+1);
  localparam logic [OPRN_WIDTH-1:0] OP_FIRST = OPRN_WIDTH'(1);
  localparam logic [OPRN_WIDTH-1:0] OP_LAST  = OPRN_WIDTH'(9);
  localparam logic [OPRN_WIDTH-1:0] OP_MUL   = OPRN_WIDTH'(3);
  localparam logic [CW-1:0]         CNT_LAST = CW'(TIMEOUT-1);

  typedef enum logic [1:0] {S_IDLE, S_READ, S_EXEC, S_WB} state_t;

  state_t                    state_q, state_d;
  logic [DATA_WIDTH-1:0]     rf_q [NREG];
  logic [REG_ADDR_WIDTH-1:0] rd_q, rd_d, rs_q, rs_d, rt_q, rt_d;
  logic [OPRN_WIDTH-1:0]     oprn_q, oprn_d, aoprn_q, aoprn_d;
  logic [DATA_WIDTH-1:0]     op1_q, op1_d, op2_q, op2_d;
  logic [DATA_WIDTH-1:0]     rl_q, rl_d, rh_q, rh_d, hi_q, hi_d;
  logic                      z_q, z_d, zf_q, zf_d;
  logic                      eto_q, eto_d, eil_q, eil_d;
  logic [CW-1:0]             cnt_q, cnt_d;

  logic                      rf_we;
  logic [REG_ADDR_WIDTH-1:0] rf_wa;
  logic [DATA_WIDTH-1:0]     rf_wd;
  logic                      accept, legal;

  assign INST_READY  = RST && (state_q == S_IDLE);
  assign BUSY        = (state_q != S_IDLE);
  assign accept      = INST_VALID && INST_READY;
  assign legal       = (INST_OPRN >= OP_FIRST) && (INST_OPRN <= OP_LAST);
  assign DBG_DATA    = rf_q[DBG_ADDR];
  assign ALU_OP1     = op1_q;
  assign ALU_OP2     = op2_q;
  assign ALU_OPRN    = aoprn_q;
  assign HI          = hi_q;
  assign ZERO_FLAG   = zf_q;
  assign ERR_TIMEOUT = eto_q;
  assign ERR_ILLEGAL = eil_q;

  always_comb begin
    state_d = state_q;
    rd_d    = rd_q;
    rs_d    = rs_q;
    rt_d    = rt_q;
    oprn_d  = oprn_q;
    aoprn_d = aoprn_q;
    op1_d   = op1_q;
    op2_d   = op2_q;
    rl_d    = rl_q;
    rh_d    = rh_q;
    z_d     = z_q;
    hi_d    = hi_q;
    zf_d    = zf_q;
    eto_d   = eto_q;
    eil_d   = eil_q;
    cnt_d   = cnt_q;
    rf_we   = 1'b0;
    rf_wa   = LD_ADDR;
    rf_wd   = LD_DATA;
    case (state_q)
      S_IDLE: begin
        // Preload lands on the accept edge, so the following READ sees it.
        rf_we = LD_EN;
        if (accept) begin
          rd_d   = INST_RD;
          rs_d   = INST_RS;
          rt_d   = INST_RT;
          oprn_d = INST_OPRN;
          if (legal) state_d = S_READ;
          else       eil_d   = 1'b1;
        end
      end
      S_READ: begin
        op1_d   = rf_q[rs_q];
        op2_d   = rf_q[rt_q];
        aoprn_d = oprn_q;
        cnt_d   = '0;
        state_d = S_EXEC;
      end
      S_EXEC: begin
        cnt_d = cnt_q + 1'b1;
        // A done seen in the first EXEC cycle may belong to the previous op.
        if ((cnt_q != '0) && ALU_DONE) begin
          rl_d    = ALU_RL;
          rh_d    = ALU_RH;
          z_d     = ALU_ZERO;
          state_d = S_WB;
        end else if (cnt_q == CNT_LAST) begin
          eto_d   = 1'b1;
          state_d = S_IDLE;
        end
      end
      S_WB: begin
        rf_we   = 1'b1;
        rf_wa   = rd_q;
        rf_wd   = rl_q;
        zf_d    = z_q;
        if (oprn_q == OP_MUL) hi_d = rh_q;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q <= S_IDLE;
      rd_q    <= '0;
      rs_q    <= '0;
      rt_q    <= '0;
      oprn_q  <= '0;
      aoprn_q <= '0;
      op1_q   <= '0;
      op2_q   <= '0;
      rl_q    <= '0;
      rh_q    <= '0;
      z_q     <= 1'b0;
      hi_q    <= '0;
      zf_q    <= 1'b0;
      eto_q   <= 1'b0;
      eil_q   <= 1'b0;
      cnt_q   <= '0;
      for (int i = 0; i < NREG; i++) rf_q[i] <= '0;
    end else begin
      state_q <= state_d;
      rd_q    <= rd_d;
      rs_q    <= rs_d;
      rt_q    <= rt_d;
      oprn_q  <= oprn_d;
      aoprn_q <= aoprn_d;
      op1_q   <= op1_d;
      op2_q   <= op2_d;
      rl_q    <= rl_d;
      rh_q    <= rh_d;
      z_q     <= z_d;
      hi_q    <= hi_d;
      zf_q    <= zf_d;
      eto_q   <= eto_d;
      eil_q   <= eil_d;
      cnt_q   <= cnt_d;
      if (rf_we) rf_q[rf_wa] <= rf_wd;
    end
  end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Randomized bench for alu_issue_ctrl: a behavioural ALU drives results, a
// transaction-level register-file model predicts writeback, flags and timing.
module tb_alu_issue_ctrl;
  localparam int TO = 16;

  logic        CLK = 1'b0, RST = 1'b0;
  logic        INST_VALID = 1'b0, INST_READY;
  logic [5:0]  INST_OPRN = '0;
  logic [3:0]  INST_RD = '0, INST_RS = '0, INST_RT = '0;
  logic        LD_EN = 1'b0;
  logic [3:0]  LD_ADDR = '0, DBG_ADDR = '0;
  logic [31:0] LD_DATA = '0, DBG_DATA, ALU_OP1, ALU_OP2, ALU_RL, ALU_RH, HI;
  logic [5:0]  ALU_OPRN;
  logic        ALU_ZERO, ALU_DONE = 1'b0, ZERO_FLAG, BUSY, ERR_TIMEOUT, ERR_ILLEGAL;

  int total = 0, bad = 0;
  logic [31:0] m [16];
  logic [31:0] m_hi;
  logic        m_zf, m_eto, m_eil;

  alu_issue_ctrl #(.DATA_WIDTH(32), .OPRN_WIDTH(6), .REG_ADDR_WIDTH(4), .TIMEOUT(TO)) dut (
    .CLK(CLK), .RST(RST), .INST_VALID(INST_VALID), .INST_READY(INST_READY),
    .INST_OPRN(INST_OPRN), .INST_RD(INST_RD), .INST_RS(INST_RS), .INST_RT(INST_RT),
    .LD_EN(LD_EN), .LD_ADDR(LD_ADDR), .LD_DATA(LD_DATA), .DBG_ADDR(DBG_ADDR),
    .DBG_DATA(DBG_DATA), .ALU_OP1(ALU_OP1), .ALU_OP2(ALU_OP2), .ALU_OPRN(ALU_OPRN),
    .ALU_RL(ALU_RL), .ALU_RH(ALU_RH), .ALU_ZERO(ALU_ZERO), .ALU_DONE(ALU_DONE),
    .HI(HI), .ZERO_FLAG(ZERO_FLAG), .BUSY(BUSY), .ERR_TIMEOUT(ERR_TIMEOUT),
    .ERR_ILLEGAL(ERR_ILLEGAL));

  always #5 CLK = ~CLK;

  // Behavioural ALU: returns {RH, RL}. Non-multiply ops return a nonzero RH so
  // that an unwanted HI update is visible.
  function automatic logic [63:0] alu_f(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] r;
    logic [31:0] junk;
    junk = a ^ 32'hA5A5_A5A5;
    case (op)
      6'd1: r = {junk, a + b};
      6'd2: r = {junk, a - b};
      6'd3: r = {32'd0, a} * {32'd0, b};
      6'd4: r = {junk, a & b};
      6'd5: r = {junk, a | b};
      6'd6: r = {junk, a ^ b};
      6'd7: r = {junk, a << b[4:0]};
      6'd8: r = {junk, a >> b[4:0]};
      6'd9: r = {junk, ~(a | b)};
      default: r = 64'd0;
    endcase
    return r;
  endfunction

  assign {ALU_RH, ALU_RL} = alu_f(ALU_OPRN, ALU_OP1, ALU_OP2);
  assign ALU_ZERO = (ALU_RL == 32'd0);

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) m[i] = '0;
    m_hi = '0; m_zf = 1'b0; m_eto = 1'b0; m_eil = 1'b0;
  endtask

  task automatic scan(input string tag);
    for (int i = 0; i < 16; i++) begin
      DBG_ADDR = 4'(i);
      #0.1;
      chk(tag, DBG_DATA, m[i]);
    end
  endtask

  task automatic preload(input logic [3:0] a, input logic [31:0] d);
    LD_EN = 1'b1; LD_ADDR = a; LD_DATA = d;
    step();
    LD_EN = 1'b0;
    m[a] = d;
  endtask

  // k: first edge index (accept edge = 0) at which ALU_DONE is high.
  // keep: leave ALU_DONE high after completion (stale done for the next op).
  task automatic issue(input logic [5:0] op, input logic [3:0] rd, input logic [3:0] rs,
                       input logic [3:0] rt, input int k, input bit keep,
                       input bit ld, input logic [3:0] la, input logic [31:0] ldd);
    int kk, endk;
    bit legal, wb;
    logic [63:0] e;
    logic [31:0] a, b;
    chk("ready_idle", INST_READY, 1);
    if (ALU_DONE) k = 0;
    INST_VALID = 1'b1; INST_OPRN = op; INST_RD = rd; INST_RS = rs; INST_RT = rt;
    LD_EN = ld; LD_ADDR = la; LD_DATA = ldd;
    ALU_DONE = (k == 0);
    if (ld) m[la] = ldd;
    legal = (op >= 6'd1) && (op <= 6'd9);
    step();
    INST_VALID = 1'b0; LD_EN = 1'b0;
    if (!legal) begin
      m_eil = 1'b1;
      chk("ill_busy", BUSY, 0);
      chk("ill_err", ERR_ILLEGAL, 1);
      chk("ill_ready", INST_READY, 1);
      return;
    end
    a = m[rs]; b = m[rt];
    e = alu_f(op, a, b);
    kk = (k < 3) ? 3 : k;
    wb = (kk <= TO + 1);
    endk = wb ? kk + 1 : TO + 1;
    for (int i = 1; i <= endk; i++) begin
      ALU_DONE = (i >= k);
      LD_EN = 1'($urandom); LD_ADDR = 4'($urandom); LD_DATA = $urandom;
      step();
      chk("busy", BUSY, (i < endk));
      if (i == 2) begin
        chk("op1", ALU_OP1, a);
        chk("op2", ALU_OP2, b);
        chk("oprn", ALU_OPRN, op);
      end
    end
    LD_EN = 1'b0;
    if (!keep || !wb) ALU_DONE = 1'b0;
    if (wb) begin
      m[rd] = e[31:0];
      m_zf = (e[31:0] == 32'd0);
      if (op == 6'd3) m_hi = e[63:32];
    end else begin
      m_eto = 1'b1;
    end
    DBG_ADDR = rd;
    #0.1;
    chk("rd_val", DBG_DATA, m[rd]);
    chk("zflag", ZERO_FLAG, m_zf);
    chk("hi", HI, m_hi);
    chk("err_to", ERR_TIMEOUT, m_eto);
    chk("err_il", ERR_ILLEGAL, m_eil);
    chk("ready_after", INST_READY, 1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    step(); step();
    chk("rst_ready", INST_READY, 0);
    chk("rst_busy", BUSY, 0);
    chk("rst_hi", HI, 0);
    chk("rst_errs", {ERR_TIMEOUT, ERR_ILLEGAL, ZERO_FLAG}, 0);
    RST = 1'b1;
    #0.1;
    chk("ready_release", INST_READY, 1);
    scan("rf_reset");

    // Directed: add, mul, sub-to-zero
    preload(4'd1, 32'd15); preload(4'd2, 32'd3);
    issue(6'h01, 4'd3, 4'd1, 4'd2, 2, 0, 0, 4'd0, 32'd0);
    chk("add_r3", m[3], 32'd18);
    preload(4'd2, 32'd5);
    issue(6'h03, 4'd4, 4'd1, 4'd2, 3, 0, 0, 4'd0, 32'd0);
    issue(6'h02, 4'd5, 4'd2, 4'd2, 4, 1, 0, 4'd0, 32'd0);
    // Stale done held from previous op; must not complete in first EXEC cycle
    issue(6'h01, 4'd6, 4'd1, 4'd1, 5, 0, 0, 4'd0, 32'd0);
    // Preload on the accept edge feeding the same instruction, RS=RT=RD
    issue(6'h06, 4'd7, 4'd7, 4'd7, 3, 0, 1, 4'd7, 32'hDEAD_BEEF);
    // Done arriving on the last EXEC cycle, then timeout
    issue(6'h05, 4'd8, 4'd1, 4'd2, TO + 1, 0, 0, 4'd0, 32'd0);
    issue(6'h01, 4'd9, 4'd1, 4'd2, 100, 0, 0, 4'd0, 32'd0);
    // Illegal opcodes, then a legal one
    issue(6'h00, 4'd1, 4'd1, 4'd1, 2, 0, 0, 4'd0, 32'd0);
    issue(6'h3F, 4'd1, 4'd1, 4'd1, 2, 0, 0, 4'd0, 32'd0);
    issue(6'h04, 4'd10, 4'd1, 4'd2, 2, 0, 0, 4'd0, 32'd0);
    scan("rf_directed");

    for (int n = 0; n < 60; n++) begin
      logic [5:0] op;
      int r, k;
      r = $urandom_range(0, 9);
      if (r == 0) op = ($urandom_range(0, 1) == 0) ? 6'h00 : 6'($urandom_range(10, 63));
      else        op = 6'($urandom_range(1, 9));
      r = $urandom_range(0, 9);
      if (r == 0)      k = 40;
      else if (r == 1) k = TO + 1;
      else             k = $urandom_range(2, 6);
      issue(op, 4'($urandom), 4'($urandom), 4'($urandom), k,
            ($urandom_range(0, 3) == 0), ($urandom_range(0, 2) == 0),
            4'($urandom), $urandom);
    end
    scan("rf_random");

    // Reset in the middle of EXEC discards the instruction
    ALU_DONE = 1'b0;
    INST_VALID = 1'b1; INST_OPRN = 6'h01; INST_RD = 4'd3; INST_RS = 4'd1; INST_RT = 4'd2;
    step();
    INST_VALID = 1'b0;
    step(); step();
    chk("pre_rst_busy", BUSY, 1);
    RST = 1'b0;
    step();
    chk("mid_rst_busy", BUSY, 0);
    chk("mid_rst_ready", INST_READY, 0);
    chk("mid_rst_ops", {ALU_OP1, ALU_OP2}, 0);
    chk("mid_rst_oprn", ALU_OPRN, 0);
    chk("mid_rst_flags", {HI, ZERO_FLAG, ERR_TIMEOUT, ERR_ILLEGAL}, 0);
    model_reset();
    scan("rf_midrst");
    RST = 1'b1;
    step();
    chk("post_rst_ready", INST_READY, 1);
    chk("post_rst_busy", BUSY, 0);
    scan("rf_post");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
